// File: rtl/digit_serial_adder.sv
`timescale 1ns / 1ps
// Digit-serial add/subtract unit: adds two WIDTH-bit operands DIGIT bits per clock,
// carrying between digits, behind valid/ready handshakes on input and output.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic             carry_q, carry_d, sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] digit_ext;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    digit_sum = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    digit_ext = WIDTH'(digit_sum[DIGIT-1:0]);
    // New digit enters at the top; after N steps the LSB digit has reached bit 0.
    res_next  = (res_q >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    carry_d  = carry_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtract is A + ~B with carryin acting as an active-high borrow-in.
          opa_d    = a;
          opb_d    = b ^ {WIDTH{subtract}};
          carry_d  = carryin ^ subtract;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1] ^ subtract;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = digit_sum[DIGIT];
        res_d   = res_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = res_next;
          cout_d  = digit_sum[DIGIT];
          ovf_d   = (sign_a_q == sign_b_q) && (res_next[WIDTH-1] != sign_a_q);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign carryout  = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
`timescale 1ns / 1ps
// Bench for digit_serial_adder: directed cases on a 16/4 instance, a 1-bit full adder,
// and a random sweep of DIGIT in {1,2,8,16} against an arithmetic reference model.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Main instance, WIDTH=16 DIGIT=4.
  logic        m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready, m_cout, m_ovf;
  logic [15:0] m_a, m_b, m_sum;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_main (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (m_in_valid),
    .in_ready (m_in_ready),
    .a        (m_a),
    .b        (m_b),
    .carryin  (m_cin),
    .subtract (m_sub),
    .out_valid(m_out_valid),
    .out_ready(m_out_ready),
    .sum      (m_sum),
    .carryout (m_cout),
    .overflow (m_ovf)
  );

  // One-bit instance.
  logic       w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf;
  logic [0:0] w_a, w_b, w_sum;

  digit_serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (w_in_valid),
    .in_ready (w_in_ready),
    .a        (w_a),
    .b        (w_b),
    .carryin  (w_cin),
    .subtract (w_sub),
    .out_valid(w_out_valid),
    .out_ready(w_out_ready),
    .sum      (w_sum),
    .carryout (w_cout),
    .overflow (w_ovf)
  );

  // Sweep instances share stimulus; each has its own outputs.
  logic        s_in_valid, s_cin, s_sub, s_out_ready;
  logic [15:0] s_a, s_b;
  logic        s_in_ready  [4];
  logic        s_out_valid [4];
  logic [15:0] s_sum       [4];
  logic        s_cout      [4];
  logic        s_ovf       [4];
  int          sweep_n     [4] = '{16, 8, 2, 1};
  logic [15:0] edge_vals   [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int unsigned D = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
    digit_serial_adder #(.WIDTH(16), .DIGIT(D)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (s_in_valid),
      .in_ready (s_in_ready[gi]),
      .a        (s_a),
      .b        (s_b),
      .carryin  (s_cin),
      .subtract (s_sub),
      .out_valid(s_out_valid[gi]),
      .out_ready(s_out_ready),
      .sum      (s_sum[gi]),
      .carryout (s_cout[gi]),
      .overflow (s_ovf[gi])
    );
  end

  // Reference: {overflow, carryout, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_op(int width, longint av, longint bv, bit cin, bit sub);
    longint mod, half, beff, ce, tot, sa, sb, st;
    logic   ovf, cout;
    logic [15:0] s;
    mod  = longint'(1) << width;
    half = mod / 2;
    beff = sub ? (mod - 1 - bv) : bv;
    ce   = longint'(cin ^ sub);
    tot  = av + beff + ce;
    s    = 16'(tot % mod);
    cout = (tot >= mod);
    sa   = (av >= half) ? av - mod : av;
    sb   = (beff >= half) ? beff - mod : beff;
    st   = sa + sb + ce;
    ovf  = (st >= half) || (st < -half);
    return {ovf, cout, s};
  endfunction

  // Presents one op to the main instance; returns edges from accept to out_valid.
  task automatic main_op(input logic [15:0] av, input logic [15:0] bv, input logic cin,
                         input logic sub, output int lat);
    m_a = av; m_b = bv; m_cin = cin; m_sub = sub; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    lat = 0;
    while (lat < 40 && !m_out_valid) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic main_release();
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_tests += 5;
    if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", m_in_ready); end
    if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", m_out_valid); end
    if (m_sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum got %h want 0000", m_sum); end
    if (m_cout !== 1'b0) begin n_fail++; $display("FAIL reset_carryout got %b want 0", m_cout); end
    if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", m_ovf); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [15:0] av [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
    logic [15:0] bv [3] = '{16'h4321, 16'h0001, 16'h0001};
    logic [15:0] es [3] = '{16'h5555, 16'h0000, 16'h8000};
    logic        ec [3] = '{1'b0, 1'b1, 1'b0};
    logic        eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      main_op(av[i], bv[i], 1'b0, 1'b0, lat);
      n_tests += 4;
      if (lat !== 4) begin n_fail++; $display("FAIL add%0d_latency got %0d want 4", i, lat); end
      if (m_sum !== es[i]) begin n_fail++; $display("FAIL add%0d_sum got %h want %h", i, m_sum, es[i]); end
      if (m_cout !== ec[i]) begin n_fail++; $display("FAIL add%0d_carryout got %b want %b", i, m_cout, ec[i]); end
      if (m_ovf !== eo[i]) begin n_fail++; $display("FAIL add%0d_overflow got %b want %b", i, m_ovf, eo[i]); end
      main_release();
      n_tests++;
      if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL add%0d_idle got in_ready=%b want 1", i, m_in_ready); end
    end
  endtask

  // Subtract with carryin=0: no borrow-in.
  task automatic test_subtract();
    logic [15:0] av [2] = '{16'h0003, 16'h8000};
    logic [15:0] bv [2] = '{16'h0005, 16'h0001};
    logic [15:0] es [2] = '{16'hFFFE, 16'h7FFF};
    logic        ec [2] = '{1'b0, 1'b1};
    logic        eo [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      main_op(av[i], bv[i], 1'b0, 1'b1, lat);
      n_tests += 4;
      if (lat !== 4) begin n_fail++; $display("FAIL sub%0d_latency got %0d want 4", i, lat); end
      if (m_sum !== es[i]) begin n_fail++; $display("FAIL sub%0d_sum got %h want %h", i, m_sum, es[i]); end
      if (m_cout !== ec[i]) begin n_fail++; $display("FAIL sub%0d_carryout got %b want %b", i, m_cout, ec[i]); end
      if (m_ovf !== eo[i]) begin n_fail++; $display("FAIL sub%0d_overflow got %b want %b", i, m_ovf, eo[i]); end
      main_release();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    main_op(16'h1111, 16'h2222, 1'b1, 1'b0, lat);
    n_tests += 2;
    if (lat !== 4) begin n_fail++; $display("FAIL bp_latency got %0d want 4", lat); end
    if (m_sum !== 16'h3334) begin n_fail++; $display("FAIL bp_sum got %h want 3334", m_sum); end
    for (int c = 0; c < 10; c++) begin
      m_in_valid = 1'($urandom_range(0, 1));
      m_a = 16'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if (m_sum !== 16'h3334 || m_cout !== 1'b0 || m_ovf !== 1'b0 || m_in_ready !== 1'b0 ||
          m_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got sum=%h c=%b v=%b ir=%b ov=%b want 3334 0 0 0 1",
                 c, m_sum, m_cout, m_ovf, m_in_ready, m_out_valid);
      end
    end
    // Handshake edge with in_valid high: must not be accepted on that same edge.
    m_in_valid = 1'b1; m_a = 16'h0100; m_b = 16'h0001; m_cin = 1'b0; m_sub = 1'b0;
    main_release();
    n_tests += 2;
    if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", m_in_ready); end
    if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", m_out_valid); end
    main_op(16'h0100, 16'h0001, 1'b0, 1'b0, lat);
    n_tests += 2;
    if (lat !== 4) begin n_fail++; $display("FAIL bp_next_latency got %0d want 4", lat); end
    if (m_sum !== 16'h0101) begin n_fail++; $display("FAIL bp_next_sum got %h want 0101", m_sum); end
    main_release();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    m_a = 16'hABCD; m_b = 16'h1357; m_cin = 1'b1; m_sub = 1'b0; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_tests += 3;
    if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", m_in_ready); end
    if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", m_out_valid); end
    if (m_sum !== 16'h0) begin n_fail++; $display("FAIL midrst_sum got %h want 0000", m_sum); end
    #2;
    reset_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      n_tests++;
      if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_discard got out_valid=%b want 0", m_out_valid); end
    end
    main_op(16'h0010, 16'h0020, 1'b0, 1'b0, lat);
    n_tests += 2;
    if (lat !== 4) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 4", lat); end
    if (m_sum !== 16'h0030) begin n_fail++; $display("FAIL midrst_next_sum got %h want 0030", m_sum); end
    main_release();
  endtask

  task automatic test_full_adder();
    logic [17:0] exp;
    int lat;
    for (int i = 0; i < 8; i++) begin
      w_a = 1'(i >> 2); w_b = 1'(i >> 1); w_cin = 1'(i); w_sub = 1'b0;
      exp = ref_op(1, longint'(w_a), longint'(w_b), w_cin, 1'b0);
      w_in_valid = 1'b1;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      lat = 0;
      while (lat < 10 && !w_out_valid) begin
        @(posedge clk); #1;
        lat++;
      end
      n_tests += 4;
      if (lat !== 1) begin n_fail++; $display("FAIL fa%0d_latency got %0d want 1", i, lat); end
      if (w_sum !== exp[0]) begin n_fail++; $display("FAIL fa%0d_sum got %b want %b", i, w_sum, exp[0]); end
      if (w_cout !== exp[16]) begin n_fail++; $display("FAIL fa%0d_carryout got %b want %b", i, w_cout, exp[16]); end
      if (w_ovf !== exp[17]) begin n_fail++; $display("FAIL fa%0d_overflow got %b want %b", i, w_ovf, exp[17]); end
      w_out_ready = 1'b1;
      @(posedge clk); #1;
      w_out_ready = 1'b0;
    end
  endtask

  task automatic test_sweep();
    logic [17:0] exp;
    int  lat [4];
    bit  seen [4];
    int  cyc;
    for (int op = 0; op < 1000; op++) begin
      s_a = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      s_b = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      s_cin = 1'($urandom_range(0, 1));
      s_sub = 1'($urandom_range(0, 1));
      exp = ref_op(16, longint'(s_a), longint'(s_b), s_cin, s_sub);
      s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin seen[i] = 1'b0; lat[i] = -1; end
      cyc = 0;
      while (cyc < 24 && !(seen[0] && seen[1] && seen[2] && seen[3])) begin
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
          if (!seen[i] && s_out_valid[i]) begin seen[i] = 1'b1; lat[i] = cyc; end
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_tests += 2;
        if (lat[i] !== sweep_n[i]) begin
          n_fail++;
          $display("FAIL sweep_n%0d_latency op %0d got %0d want %0d", sweep_n[i], op, lat[i], sweep_n[i]);
        end
        if ({s_ovf[i], s_cout[i], s_sum[i]} !== exp) begin
          n_fail++;
          $display("FAIL sweep_n%0d_result op %0d a=%h b=%h ci=%b sub=%b got v=%b c=%b s=%h want v=%b c=%b s=%h",
                   sweep_n[i], op, s_a, s_b, s_cin, s_sub, s_ovf[i], s_cout[i], s_sum[i],
                   exp[17], exp[16], exp[15:0]);
        end
      end
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
    end
  endtask

  initial begin
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    test_reset();
    test_add();
    test_subtract();
    test_backpressure();
    test_reset_mid_run();
    test_full_adder();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
